// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared FSM encoding and port-width helper for the FIFO read controller
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } rd_state_e;

  // Width of the FIFO rdusedw port for a given depth code.
  function automatic int usedw_w(input int depth);
    return (depth >> 1) + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_if.sv
// rtl/fifo_rd_if.sv - valid/ready output stream of the FIFO read controller
interface fifo_rd_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry skid buffer, strict FIFO order, flush has priority
module fifo_rd_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (occ != 2'd0);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - burst read controller draining an async FIFO into a skid-buffered stream
// Optional word counter enabled by FIFO_RD_CNT_EN.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int BURST   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                      rdclk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          fifo_q,
  input  logic                      fifo_empty,
  input  logic [usedw_w(DEPTH)-1:0] fifo_rdusedw,
  output logic                      fifo_rd,
  input  logic                      flush,
  fifo_rd_if.master                 strm,
  output logic                      busy
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]               word_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BURST + 1);

  rd_state_e       state, state_n;
  logic [TW-1:0]   timer;
  logic [BW-1:0]   rd_cnt;
  logic            inflight;
  logic [1:0]      occ;
  logic            pop;
  logic            room;

  assign pop = strm.m_valid & strm.m_ready;
  // A new read is allowed only if its word is guaranteed a free skid slot on arrival.
  assign room = ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) <= 3'd1;

  fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .clk   (rdclk),
    .rst   (rst),
    .flush (flush),
    .push  (inflight),
    .din   (fifo_q),
    .pop   (pop),
    .dout  (strm.m_data),
    .valid (strm.m_valid),
    .occ   (occ)
  );

  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    fifo_rd = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (fifo_empty) begin
          state_n = S_IDLE;
        end else if (32'(fifo_rdusedw) >= BURST || 32'(timer) == TIMEOUT) begin
          state_n = S_BURST;
        end
      end
      S_BURST: begin
        fifo_rd = !fifo_empty && (32'(rd_cnt) < BURST) && room;
        if (fifo_empty || (fifo_rd && 32'(rd_cnt) == BURST - 1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (flush) begin
      state_n = S_IDLE;
      fifo_rd = 1'b0;
    end
  end

  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      timer    <= '0;
      rd_cnt   <= '0;
    end else begin
      inflight <= fifo_rd;
      if (state == S_WAIT) begin
        if (32'(timer) != TIMEOUT) timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end
      if (state == S_BURST) begin
        if (fifo_rd && 32'(rd_cnt) != BURST) rd_cnt <= rd_cnt + 1'b1;
      end else begin
        rd_cnt <= '0;
      end
    end
  end

  assign busy = (state != S_IDLE) || (occ != 2'd0) || inflight;

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (pop && !flush) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - scoreboard bench for fifo_rd_ctrl with a behavioural FIFO model
module tb_fifo_rd_ctrl;

  logic       rdclk = 1'b0;
  logic       rst;
  logic [7:0] fifo_q = 8'd0;
  logic       fifo_empty = 1'b1;
  logic [2:0] fifo_rdusedw = 3'd0;
  logic       fifo_rd;
  logic       flush;
  logic       busy;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] word_cnt;
`endif

  fifo_rd_if #(.WIDTH(8)) strm ();

  fifo_rd_ctrl #(.WIDTH(8), .DEPTH(4), .BURST(2), .TIMEOUT(15)) dut (
    .rdclk        (rdclk),
    .rst          (rst),
    .fifo_q       (fifo_q),
    .fifo_empty   (fifo_empty),
    .fifo_rdusedw (fifo_rdusedw),
    .fifo_rd      (fifo_rd),
    .flush        (flush),
    .strm         (strm),
    .busy         (busy)
`ifdef FIFO_RD_CNT_EN
    ,
    .word_cnt     (word_cnt)
`endif
  );

  always #5 rdclk = ~rdclk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         npop = 0;
  int         first_v = -1;
  int         w_cyc;
  int         nwr;
  bit         sb_en = 1'b1;
  bit         stall = 1'b0;
  logic [7:0] hold_d;
  logic [7:0] fmem[$];
  logic [7:0] wq[$];
  logic [7:0] sb[$];
  int         rd_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: writes land at the next edge, read data appears the cycle after fifo_rd.
  always @(posedge rdclk) begin
    if (rst === 1'b1) begin
      fmem.delete();
      wq.delete();
    end else begin
      if (fifo_rd === 1'b1 && fmem.size() > 0) fifo_q <= fmem.pop_front();
      while (wq.size() > 0) fmem.push_back(wq.pop_front());
    end
    fifo_empty   <= (fmem.size() == 0);
    fifo_rdusedw <= (fmem.size() > 7) ? 3'd7 : 3'(fmem.size());
  end

  always @(negedge rdclk) begin
    cyc++;
    if (rst !== 1'b0) begin
      stall = 1'b0;
    end else begin
      if (fifo_rd === 1'b1) begin
        rd_log.push_back(cyc);
        chk("no_underflow", {31'd0, fifo_empty}, 32'd0);
      end
      if (stall && strm.m_valid === 1'b1) chk("hold_data", {24'd0, strm.m_data}, {24'd0, hold_d});
      if (strm.m_valid === 1'b1 && first_v < 0) first_v = cyc;
      if (strm.m_valid === 1'b1 && strm.m_ready === 1'b1) begin
        npop++;
        if (sb_en) begin
          chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) chk("sb_data", {24'd0, strm.m_data}, {24'd0, sb.pop_front()});
        end
      end
      stall  = (strm.m_valid === 1'b1) && (strm.m_ready === 1'b0);
      hold_d = strm.m_data;
    end
  end

  task automatic tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic fifo_write(input logic [7:0] d);
    wq.push_back(d);
    if (sb_en) sb.push_back(d);
  endtask

  task automatic drain(input string tag);
    int i = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && i < 300) begin
      tick();
      i++;
    end
    chk({tag, "_drain"}, {31'd0, (sb.size() == 0) && (busy === 1'b0)}, 32'd1);
  endtask

  task automatic wait_rd(input string tag, input int n);
    int i = 0;
    while (rd_log.size() < n && i < 100) begin
      tick();
      i++;
    end
    chk({tag, "_rd_seen"}, {31'd0, rd_log.size() >= n}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    strm.m_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    chk("rst_m_valid", {31'd0, strm.m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, strm.m_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Two back-to-back bursts of two from a preloaded FIFO.
    strm.m_ready = 1'b1;
    rd_log.delete();
    first_v = -1;
    for (int i = 0; i < 4; i++) fifo_write(8'hA0 + 8'(i));
    drain("t2");
    chk("t2_rd_count", rd_log.size(), 32'd4);
    if (rd_log.size() == 4) begin
      chk("t2_burst1_len", rd_log[1] - rd_log[0], 32'd1);
      chk("t2_burst_gap", rd_log[2] - rd_log[1], 32'd3);
      chk("t2_burst2_len", rd_log[3] - rd_log[2], 32'd1);
      chk("t2_latency", first_v - rd_log[0], 32'd2);
    end

    // Single word forces a partial burst after the WAIT timeout.
    rd_log.delete();
    w_cyc = cyc;
    fifo_write(8'h5A);
    drain("t3");
    chk("t3_rd_count", rd_log.size(), 32'd1);
    if (rd_log.size() == 1) chk("t3_timeout_cycle", rd_log[0], w_cyc + 19);

    // Back-pressure: skid fills to two and reads stop until the consumer is ready.
    strm.m_ready = 1'b0;
    rd_log.delete();
    for (int i = 0; i < 4; i++) fifo_write(8'hF0 + 8'(i));
    repeat (15) tick();
    chk("t4_rd_stalled", rd_log.size(), 32'd2);
    chk("t4_valid", {31'd0, strm.m_valid}, 32'd1);
    chk("t4_head", {24'd0, strm.m_data}, 32'hF0);
    strm.m_ready = 1'b1;
    drain("t4");
    chk("t4_rd_total", rd_log.size(), 32'd4);

    // Flush with a full skid: buffered words are discarded.
    strm.m_ready = 1'b0;
    rd_log.delete();
    for (int i = 0; i < 4; i++) fifo_write(8'hB0 + 8'(i));
    repeat (10) tick();
    void'(sb.pop_front());
    void'(sb.pop_front());
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5a_valid", {31'd0, strm.m_valid}, 32'd0);
    chk("t5a_idle", {31'd0, busy}, 32'd0);
    strm.m_ready = 1'b1;
    drain("t5a");
    chk("t5a_rd_total", rd_log.size(), 32'd4);

    // Flush with a read in flight: that word is dropped and the next read suppressed.
    strm.m_ready = 1'b0;
    rd_log.delete();
    for (int i = 0; i < 3; i++) fifo_write(8'hE0 + 8'(i));
    wait_rd("t5b", 1);
    void'(sb.pop_front());
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5b_valid", {31'd0, strm.m_valid}, 32'd0);
    chk("t5b_idle", {31'd0, busy}, 32'd0);
    chk("t5b_rd_suppressed", rd_log.size(), 32'd1);
    strm.m_ready = 1'b1;
    drain("t5b");
    chk("t5b_rd_total", rd_log.size(), 32'd3);

    // Reset mid-burst with a read in flight.
    strm.m_ready = 1'b0;
    rd_log.delete();
    for (int i = 0; i < 4; i++) fifo_write(8'hC0 + 8'(i));
    wait_rd("t1", 1);
    rst = 1'b1;
    #1;
    chk("t1_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    chk("t1_m_valid", {31'd0, strm.m_valid}, 32'd0);
    chk("t1_m_data", {24'd0, strm.m_data}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    repeat (2) tick();
    rst = 1'b0;
    strm.m_ready = 1'b1;
    rd_log.delete();
    repeat (6) tick();
    chk("t1_no_capture", {31'd0, strm.m_valid}, 32'd0);
    chk("t1_no_read", rd_log.size(), 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

`ifdef FIFO_RD_CNT_EN
    // Long stream wraps the 16-bit word counter.
    sb_en = 1'b0;
    npop = 0;
    nwr = 0;
    for (int i = 0; i < 200000 && npop < 70000; i++) begin
      if (nwr < 70000 && fmem.size() + wq.size() < 6) begin
        fifo_write(8'(nwr));
        nwr++;
      end
      tick();
    end
    chk("t6_pops", npop, 32'd70000);
    chk("t6_word_cnt", {16'd0, word_cnt}, 32'd4464);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
